// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit in front of a word-addressed data memory.
// Memory reads are combinational and writes are synchronous. Byte and halfword
// stores use a read-modify-write sequence. Each accepted request gets exactly one
// response.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req_*             request handshake from the core (valid/ready, we, funct3, addr, wdata)
//   resp_*            one-cycle response pulse carrying the extended load data and
//                     the misaligned flag
//   mem_*             data memory port (we, word-aligned addr, wdata, rdata)
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  When defined, misaligned H/HU/SH and W/SW requests skip
//                         memory and respond with resp_misaligned=1.
//                         When undefined, the offending low address bits are cleared
//                         and the access proceeds aligned.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;

    // funct3[1:0]: 00 byte, 01 halfword, anything else is treated as a word.
    logic        req_half, req_word;
    logic [31:0] req_addr_al;
    assign req_half    = (req_funct3[1:0] == 2'b01);
    assign req_word    = req_funct3[1];
    assign req_addr_al = req_word ? {req_addr[31:2], 2'b00} :
                         req_half ? {req_addr[31:1], 1'b0}  : req_addr;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic req_mis;
    assign req_mis = (req_half & req_addr[0]) | (req_word & (|req_addr[1:0]));
`endif

    // Load lane selection and extension.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    always_comb begin
        ld_byte = mem_rdata[7:0];
        unique case (addr_q[1:0])
            2'b00: ld_byte = mem_rdata[7:0];
            2'b01: ld_byte = mem_rdata[15:8];
            2'b10: ld_byte = mem_rdata[23:16];
            2'b11: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Merge store data into the latched word for SB/SH.
    logic [31:0] merged;
    always_comb begin
        merged = word_q;
        if (funct3_q[1:0] == 2'b00) begin
            unique case (addr_q[1:0])
                2'b00: merged[7:0]   = wdata_q[7:0];
                2'b01: merged[15:8]  = wdata_q[7:0];
                2'b10: merged[23:16] = wdata_q[7:0];
                2'b11: merged[31:24] = wdata_q[7:0];
                default: merged = word_q;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d      = mis_q;
`endif
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr_al;
                    wdata_d  = req_wdata;
                    state_d  = StAccess;
                    if (req_we) rdata_d = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d = req_mis;
                    if (req_mis) begin
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end
`endif
                end
            end
            StAccess: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (!we_q) begin
                    rdata_d = ld_ext;
                    state_d = StResp;
                end else if (funct3_q[1]) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = StResp;
                end else begin
                    word_d  = mem_rdata;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = 1'b1;
                mem_wdata = merged;
                state_d   = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset must suppress a pending write in the same cycle it is asserted.
        if (reset) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = 32'h0;
            mem_wdata  = 32'h0;
        end
    end

    assign resp_rdata = reset ? 32'h0 : rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_misaligned = mis_q & resp_valid;
`else
    assign resp_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    load_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it cycle by cycle until its response.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd_exp, input int lat, input int we_cyc,
                           input logic [31:0] wa, input logic [31:0] wv, input logic mis);
        logic [31:0] e;
        bit          got;
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 1);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        exp_q.push_back(rd_exp);
        got = 0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(negedge clk);
            check({tag, "_mem_we"}, mem_we, (k == we_cyc));
            if (k == we_cyc) begin
                check({tag, "_mem_addr"}, mem_addr, wa);
                check({tag, "_mem_wdata"}, mem_wdata, wv);
            end
            if (resp_valid) begin
                got = 1;
                check({tag, "_latency"}, k, lat);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                check({tag, "_rdata"}, resp_rdata, e);
                check({tag, "_misaligned"}, resp_misaligned, mis);
            end else begin
                check({tag, "_busy"}, req_ready, 0);
            end
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [31:0] vals [4];
        logic [31:0] addrs [4];
        int          rcyc [4];
        int          acc, nresp;
        bit          acc_now;
        logic [31:0] e;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = 32'h8899AABB;
        mem[32'h24 >> 2] = 32'h11223344;
        mem[32'h30 >> 2] = 32'hCAFEF00D;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        // Reset values
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_mis", resp_misaligned, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;

        // Loads with extension
        run_req("lb13",  0, 3'b000, 32'h13, 0, 32'hFFFFFF88, 2, 0, 0, 0, 0);
        run_req("lbu13", 0, 3'b100, 32'h13, 0, 32'h00000088, 2, 0, 0, 0, 0);
        run_req("lh12",  0, 3'b001, 32'h12, 0, 32'hFFFF8899, 2, 0, 0, 0, 0);
        run_req("lhu10", 0, 3'b101, 32'h10, 0, 32'h0000AABB, 2, 0, 0, 0, 0);
        run_req("lb11",  0, 3'b000, 32'h11, 0, 32'hFFFFFFAA, 2, 0, 0, 0, 0);

        // Stores
        run_req("sw20", 1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 2, 1, 32'h20, 32'hDEADBEEF, 0);
        run_req("lw20", 0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 2, 0, 0, 0, 0);
        run_req("sb25", 1, 3'b000, 32'h25, 32'hFFFFFFAA, 0, 3, 2, 32'h24, 32'h1122AA44, 0);
        run_req("sh26", 1, 3'b001, 32'h26, 32'h00005566, 0, 3, 2, 32'h24, 32'h5566AA44, 0);
        check("mem24", mem[32'h24 >> 2], 32'h5566AA44);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        run_req("lw31", 0, 3'b010, 32'h31, 0, 0, 1, 0, 0, 0, 1);
        run_req("lh27", 0, 3'b001, 32'h27, 0, 0, 1, 0, 0, 0, 1);
`else
        run_req("lw31", 0, 3'b010, 32'h31, 0, 32'hCAFEF00D, 2, 0, 0, 0, 0);
        run_req("lh27", 0, 3'b001, 32'h27, 0, 32'h00005566, 2, 0, 0, 0, 0);
`endif

        // Reset during the WRITE cycle of an SB
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h24; req_wdata = 32'h11;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rstw_mem_we", mem_we, 0);
        check("rstw_resp_valid", resp_valid, 0);
        check("rstw_ready", req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstw_ready_after", req_ready, 1);
        for (int k = 0; k < 3; k++) begin
            check("rstw_no_resp", resp_valid, 0);
            check("rstw_no_we", mem_we, 0);
            @(negedge clk);
        end
        check("rstw_mem24", mem[32'h24 >> 2], 32'h5566AA44);

        // Back-to-back loads with req_valid held high
        addrs[0] = 32'h10; vals[0] = 32'h8899AABB;
        addrs[1] = 32'h20; vals[1] = 32'hDEADBEEF;
        addrs[2] = 32'h24; vals[2] = 32'h5566AA44;
        addrs[3] = 32'h30; vals[3] = 32'hCAFEF00D;
        acc = 0; nresp = 0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = addrs[0]; req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            acc_now = 0;
            if (resp_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                check("b2b_rdata", resp_rdata, e);
                if (nresp < 4) rcyc[nresp] = c;
                nresp++;
            end
            if (req_valid && req_ready) begin
                if (acc < 4) exp_q.push_back(vals[acc]);
                acc++;
                acc_now = 1;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (acc >= 4) req_valid = 1'b0;
                else req_addr = addrs[acc];
            end
        end
        check("b2b_accepted", acc, 4);
        check("b2b_responses", nresp, 4);
        if (nresp >= 4) begin
            for (int i = 0; i < 3; i++) check("b2b_spacing", rcyc[i+1] - rcyc[i], 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
